// File: rtl/postfix_pkg.sv
// Shared types and constants for the postfix expression evaluator.
package postfix_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PUSH_NUM,
        POP_B,
        POP_A,
        CALC,
        PUSH_RES,
        POP_FINAL,
        ERR
    } state_e;

    typedef enum logic [1:0] {
        ADD,
        SUB,
        MUL,
        DIV
    } op_e;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_MALFORMED = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
    localparam logic [1:0] ERR_DIV_ZERO  = 2'd3;

    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    localparam logic [7:0] ASCII_SLASH = 8'h2F;

    typedef struct packed {
        logic valid;
        op_e  op;
    } sign_dec_t;

    function automatic sign_dec_t decode_sign(input logic [7:0] c);
        sign_dec_t d;
        d.valid = 1'b1;
        d.op    = ADD;
        case (c)
            ASCII_PLUS:  d.op = ADD;
            ASCII_MINUS: d.op = SUB;
            ASCII_STAR:  d.op = MUL;
            ASCII_SLASH: d.op = DIV;
            default:     d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/postfix_eval_if.sv
// Push/pop handshake bus between the evaluator (master) and its stack (slave).
interface postfix_eval_if;
    logic        PUSH_STB;
    logic [31:0] PUSH_DAT;
    logic        PUSH_ACK;
    logic        POP_STB;
    logic [31:0] POP_DAT;
    logic        POP_ACK;

    modport master (
        output PUSH_STB, PUSH_DAT, POP_STB,
        input  PUSH_ACK, POP_DAT, POP_ACK
    );

    modport slave (
        input  PUSH_STB, PUSH_DAT, POP_STB,
        output PUSH_ACK, POP_DAT, POP_ACK
    );
endinterface

// File: rtl/postfix_alu.sv
// Combinational two's-complement ALU: wrapping add/sub/mul, signed truncating divide.
module postfix_alu
    import postfix_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  op_e           op_i,
    output logic [DW-1:0] res_o,
    output logic          div_zero_o
);

    always_comb begin
        res_o      = '0;
        div_zero_o = 1'b0;
        case (op_i)
            ADD: res_o = a_i + b_i;
            SUB: res_o = a_i - b_i;
            MUL: res_o = a_i * b_i;
            DIV: begin
                if (b_i == '0) begin
                    div_zero_o = 1'b1;
                end else begin
                    res_o = $unsigned($signed(a_i) / $signed(b_i));
                end
            end
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/postfix_eval.sv
// Postfix token evaluator: sequences an external stack through push/pop handshakes
// and reduces each operator with a combinational ALU.
module postfix_eval
    import postfix_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [7:0]    IN_NUMBER,
    input  logic          IN_NUMBER_STB,
    input  logic [7:0]    IN_SIGN,
    input  logic          IN_SIGN_STB,
    output logic          BUSY,
    postfix_eval_if.master stk,
    output logic [DW-1:0] RESULT,
    output logic          RESULT_STB,
    output logic          ERROR,
    output logic [1:0]    ERR_CODE
);

    localparam int CW = $clog2(DEPTH + 1);

    state_e        state_q;
    logic          push_stb_q;
    logic          pop_stb_q;
    logic [31:0]   push_dat_q;
    logic [DW-1:0] result_q;
    logic          result_stb_q;
    logic          error_q;
    logic [1:0]    err_code_q;
    logic [CW-1:0] depth_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    op_e           op_q;

    sign_dec_t     sdec;
    logic          tok_end;
    logic          tok_num;
    logic          tok_sign;
    logic [DW-1:0] alu_res;
    logic          alu_div_zero;
    logic          unused_pop_hi;

    assign sdec     = decode_sign(IN_SIGN);
    // Both strobes together form the end marker, which outranks either alone.
    assign tok_end  = IN_NUMBER_STB & IN_SIGN_STB;
    assign tok_num  = IN_NUMBER_STB & ~IN_SIGN_STB;
    assign tok_sign = IN_SIGN_STB & ~IN_NUMBER_STB;

    assign unused_pop_hi = ^stk.POP_DAT[31:DW];

    postfix_alu #(
        .DW(DW)
    ) u_alu (
        .a_i        (a_q),
        .b_i        (b_q),
        .op_i       (op_q),
        .res_o      (alu_res),
        .div_zero_o (alu_div_zero)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            push_stb_q   <= 1'b0;
            pop_stb_q    <= 1'b0;
            push_dat_q   <= '0;
            result_q     <= '0;
            result_stb_q <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= ERR_NONE;
            depth_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= ADD;
        end else begin
            result_stb_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (tok_end) begin
                        if (depth_q == CW'(1)) begin
                            state_q <= POP_FINAL;
                        end else begin
                            state_q    <= ERR;
                            error_q    <= 1'b1;
                            err_code_q <= ERR_MALFORMED;
                        end
                    end else if (tok_num) begin
                        if (depth_q == CW'(DEPTH)) begin
                            state_q    <= ERR;
                            error_q    <= 1'b1;
                            err_code_q <= ERR_OVERFLOW;
                        end else begin
                            push_dat_q <= 32'(IN_NUMBER);
                            state_q    <= PUSH_NUM;
                        end
                    end else if (tok_sign && sdec.valid) begin
                        if (depth_q < CW'(2)) begin
                            state_q    <= ERR;
                            error_q    <= 1'b1;
                            err_code_q <= ERR_MALFORMED;
                        end else begin
                            op_q    <= sdec.op;
                            state_q <= POP_B;
                        end
                    end
                end

                // Strobe is raised one cycle after entry and held until the ack.
                PUSH_NUM, PUSH_RES: begin
                    if (stk.PUSH_ACK) begin
                        push_stb_q <= 1'b0;
                        depth_q    <= depth_q + CW'(1);
                        state_q    <= IDLE;
                    end else begin
                        push_stb_q <= 1'b1;
                    end
                end

                POP_B: begin
                    if (stk.POP_ACK) begin
                        b_q       <= stk.POP_DAT[DW-1:0];
                        pop_stb_q <= 1'b0;
                        depth_q   <= depth_q - CW'(1);
                        state_q   <= POP_A;
                    end else begin
                        pop_stb_q <= 1'b1;
                    end
                end

                POP_A: begin
                    if (stk.POP_ACK) begin
                        a_q       <= stk.POP_DAT[DW-1:0];
                        pop_stb_q <= 1'b0;
                        depth_q   <= depth_q - CW'(1);
                        state_q   <= CALC;
                    end else begin
                        pop_stb_q <= 1'b1;
                    end
                end

                CALC: begin
                    if (alu_div_zero) begin
                        state_q    <= ERR;
                        error_q    <= 1'b1;
                        err_code_q <= ERR_DIV_ZERO;
                    end else begin
                        push_dat_q <= 32'(alu_res);
                        state_q    <= PUSH_RES;
                    end
                end

                POP_FINAL: begin
                    if (stk.POP_ACK) begin
                        result_q     <= stk.POP_DAT[DW-1:0];
                        result_stb_q <= 1'b1;
                        pop_stb_q    <= 1'b0;
                        depth_q      <= '0;
                        state_q      <= IDLE;
                    end else begin
                        pop_stb_q <= 1'b1;
                    end
                end

                ERR: begin
                    state_q <= ERR;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign BUSY         = (state_q != IDLE);
    assign stk.PUSH_STB = push_stb_q;
    assign stk.PUSH_DAT = push_dat_q;
    assign stk.POP_STB  = pop_stb_q;
    assign RESULT       = result_q;
    assign RESULT_STB   = result_stb_q;
    assign ERROR        = error_q;
    assign ERR_CODE     = err_code_q;

endmodule

// File: tb/tb_postfix_eval.sv
// Bench for postfix_eval: stack model on the bus, table vectors, corner sequences,
// and random expressions scored against a queue-based postfix evaluator.
module tb_postfix_eval;

    typedef struct {
        bit         is_num;
        bit         is_end;
        logic [7:0] val;
    } tok_t;

    typedef struct {
        string       expr;
        logic [15:0] res;
        logic [1:0]  err;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic [1:0]  err;
    } mres_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  IN_NUMBER = 8'h00;
    logic        IN_NUMBER_STB = 1'b0;
    logic [7:0]  IN_SIGN = 8'h00;
    logic        IN_SIGN_STB = 1'b0;
    logic        BUSY;
    logic [15:0] RESULT;
    logic        RESULT_STB;
    logic        ERROR;
    logic [1:0]  ERR_CODE;

    postfix_eval_if stk ();

    postfix_eval #(
        .DW(16),
        .DEPTH(16)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .IN_NUMBER     (IN_NUMBER),
        .IN_NUMBER_STB (IN_NUMBER_STB),
        .IN_SIGN       (IN_SIGN),
        .IN_SIGN_STB   (IN_SIGN_STB),
        .BUSY          (BUSY),
        .stk           (stk.master),
        .RESULT        (RESULT),
        .RESULT_STB    (RESULT_STB),
        .ERROR         (ERROR),
        .ERR_CODE      (ERR_CODE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passed = 0;
    tok_t toks[$];

    // Stack slave model
    logic [31:0] mem [32];
    int sp = 0;
    int pushes = 0;
    int wcnt = 0;
    int bad_pop = 0;
    int bad_both = 0;
    int ack_delay = 0;
    bit hold_ack = 1'b0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            stk.PUSH_ACK <= 1'b0;
            stk.POP_ACK  <= 1'b0;
            stk.POP_DAT  <= '0;
            sp           <= 0;
            wcnt         <= 0;
        end else begin
            stk.PUSH_ACK <= 1'b0;
            stk.POP_ACK  <= 1'b0;
            if (!hold_ack && stk.PUSH_STB && !stk.PUSH_ACK) begin
                if (wcnt >= ack_delay) begin
                    if (sp < 32) mem[sp] <= stk.PUSH_DAT;
                    sp           <= sp + 1;
                    pushes       <= pushes + 1;
                    stk.PUSH_ACK <= 1'b1;
                    wcnt         <= 0;
                end else begin
                    wcnt <= wcnt + 1;
                end
            end else if (!hold_ack && stk.POP_STB && !stk.POP_ACK) begin
                if (wcnt >= ack_delay) begin
                    if (sp == 0) begin
                        bad_pop <= bad_pop + 1;
                    end else begin
                        stk.POP_DAT <= mem[sp-1];
                        sp          <= sp - 1;
                    end
                    stk.POP_ACK <= 1'b1;
                    wcnt        <= 0;
                end else begin
                    wcnt <= wcnt + 1;
                end
            end
        end
    end

    int res_count = 0;
    logic [15:0] last_res = '0;

    always @(negedge CLK) begin
        if (RESULT_STB) begin
            res_count <= res_count + 1;
            last_res  <= RESULT;
        end
        if (stk.PUSH_STB && stk.POP_STB) bad_both <= bad_both + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: bound expired, got timeout, expected completion", name);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic parse(input string s);
        int i;
        int v;
        logic [7:0] c;
        toks.delete();
        i = 0;
        while (i < s.len()) begin
            c = s[i];
            if (c == 8'h20) begin
                i++;
            end else if (c >= 8'h30 && c <= 8'h39) begin
                v = 0;
                while (i < s.len() && s[i] >= 8'h30 && s[i] <= 8'h39) begin
                    v = v * 10 + int'(s[i]) - 48;
                    i++;
                end
                toks.push_back('{1'b1, 1'b0, v[7:0]});
            end else begin
                if (c == 8'h3D) toks.push_back('{1'b0, 1'b1, 8'h00});
                else            toks.push_back('{1'b0, 1'b0, c});
                i++;
            end
        end
    endtask

    // Returns 0 when ready for a token, 1 when the DUT has flagged an error, 2 on timeout.
    task automatic wait_ready(output int st);
        for (int i = 0; i < 200; i++) begin
            if (ERROR) begin st = 1; return; end
            if (!BUSY) begin st = 0; return; end
            @(negedge CLK);
        end
        st = 2;
    endtask

    task automatic send_tok(input tok_t t);
        if (t.is_end) begin
            IN_NUMBER_STB = 1'b1;
            IN_SIGN_STB   = 1'b1;
        end else if (t.is_num) begin
            IN_NUMBER     = t.val;
            IN_NUMBER_STB = 1'b1;
        end else begin
            IN_SIGN     = t.val;
            IN_SIGN_STB = 1'b1;
        end
        @(negedge CLK);
        IN_NUMBER_STB = 1'b0;
        IN_SIGN_STB   = 1'b0;
    endtask

    task automatic run_expr(input string name, input logic [15:0] exp_res, input logic [1:0] exp_err);
        int base_res = res_count;
        int st;
        bit stop = 1'b0;
        bit done = 1'b0;
        foreach (toks[i]) begin
            if (!stop) begin
                wait_ready(st);
                if (st == 0) send_tok(toks[i]);
                else begin
                    stop = 1'b1;
                    if (st == 2) fail_now({name, "_ready"});
                end
            end
        end
        for (int i = 0; i < 300 && !done; i++) begin
            if (exp_err == 2'd0) done = (res_count > base_res);
            else                 done = ERROR;
            if (!done) @(negedge CLK);
        end
        if (!done) fail_now({name, "_done"});
        repeat (3) @(negedge CLK);
        check({name, "_err_code"}, 32'(ERR_CODE), 32'(exp_err));
        check({name, "_error"}, 32'(ERROR), 32'(exp_err != 2'd0));
        check({name, "_busy"}, 32'(BUSY), 32'(exp_err != 2'd0));
        check({name, "_nres"}, 32'(res_count - base_res), (exp_err == 2'd0) ? 32'd1 : 32'd0);
        if (exp_err == 2'd0) begin
            check({name, "_result"}, 32'(last_res), 32'(exp_res));
            check({name, "_depth"}, 32'(sp), 32'd0);
        end else begin
            check({name, "_quiet"}, 32'({stk.PUSH_STB, stk.POP_STB}), 32'd0);
            do_reset();
        end
    endtask

    function automatic mres_t model(input tok_t tq[$]);
        logic [15:0] st[$];
        mres_t m;
        int sa, sb, r;
        logic [15:0] a, b;
        m.res = '0;
        m.err = 2'd0;
        foreach (tq[i]) begin
            if (tq[i].is_end) begin
                if (st.size() != 1) m.err = 2'd1;
                else m.res = st.pop_back();
                return m;
            end else if (tq[i].is_num) begin
                if (st.size() >= 16) begin m.err = 2'd2; return m; end
                st.push_back({8'h00, tq[i].val});
            end else if (tq[i].val inside {8'h2B, 8'h2D, 8'h2A, 8'h2F}) begin
                if (st.size() < 2) begin m.err = 2'd1; return m; end
                b = st.pop_back();
                a = st.pop_back();
                sa = int'($signed(a));
                sb = int'($signed(b));
                case (tq[i].val)
                    8'h2B: r = sa + sb;
                    8'h2D: r = sa - sb;
                    8'h2A: r = sa * sb;
                    default: begin
                        if (sb == 0) begin m.err = 2'd3; return m; end
                        r = sa / sb;
                    end
                endcase
                st.push_back(r[15:0]);
            end
        end
        return m;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit, expected $finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[$];
    logic [7:0] opc [4];
    mres_t m;
    int st;
    int nums, pushed, d, base_push;
    bit seen;
    logic [7:0] v;

    initial begin
        opc = '{8'h2B, 8'h2D, 8'h2A, 8'h2F};
        vecs.push_back('{"3 4 + =",             16'd7,     2'd0});
        vecs.push_back('{"2 3 4 * + =",         16'd14,    2'd0});
        vecs.push_back('{"9 2 - =",             16'd7,     2'd0});
        vecs.push_back('{"0 7 - 2 / =",         16'hFFFD,  2'd0});
        vecs.push_back('{"50 0 7 - / =",        16'hFFF9,  2'd0});
        vecs.push_back('{"7 0 / =",             16'd0,     2'd3});
        vecs.push_back('{"1 =",                 16'd1,     2'd0});
        vecs.push_back('{"+ =",                 16'd0,     2'd1});
        vecs.push_back('{"1 2 =",               16'd0,     2'd1});
        vecs.push_back('{"=",                   16'd0,     2'd1});
        vecs.push_back('{"5 3 % + =",           16'd8,     2'd0});
        vecs.push_back('{"200 100 * =",         16'h4E20,  2'd0});
        vecs.push_back('{"255 255 * 255 * =",   16'h02FF,  2'd0});
        vecs.push_back('{"100 7 - 3 / 2 * =",   16'd62,    2'd0});

        #1 RST = 1'b1;
        #2;
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_push_stb", 32'(stk.PUSH_STB), 32'd0);
        check("rst_pop_stb", 32'(stk.POP_STB), 32'd0);
        check("rst_push_dat", stk.PUSH_DAT, 32'd0);
        check("rst_result", 32'(RESULT), 32'd0);
        check("rst_result_stb", 32'(RESULT_STB), 32'd0);
        check("rst_error", 32'(ERROR), 32'd0);
        check("rst_err_code", 32'(ERR_CODE), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        foreach (vecs[i]) begin
            parse(vecs[i].expr);
            run_expr($sformatf("vec%0d", i), vecs[i].res, vecs[i].err);
        end

        // 17 numbers into a 16-deep stack: the last one must not reach the bus
        toks.delete();
        for (int i = 0; i < 17; i++) toks.push_back('{1'b1, 1'b0, 8'(i + 1)});
        toks.push_back('{1'b0, 1'b1, 8'h00});
        base_push = pushes;
        run_expr("overflow", 16'd0, 2'd2);
        check("overflow_pushes", 32'(pushes - base_push), 32'd16);

        // Reset while a push is outstanding with its ack withheld
        hold_ack = 1'b1;
        wait_ready(st);
        if (st != 0) fail_now("hold_ready");
        send_tok('{1'b1, 1'b0, 8'd9});
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            seen = stk.PUSH_STB;
            if (!seen) @(negedge CLK);
        end
        check("hold_push_stb", 32'(seen), 32'd1);
        #2 RST = 1'b1;
        #1;
        check("rst_async_push_stb", 32'(stk.PUSH_STB), 32'd0);
        check("rst_async_busy", 32'(BUSY), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        hold_ack = 1'b0;
        parse("5 =");
        run_expr("after_rst", 16'd5, 2'd0);

        for (int it = 0; it < 40; it++) begin
            nums = int'($urandom_range(1, 9));
            pushed = 0;
            d = 0;
            ack_delay = int'($urandom_range(0, 2));
            toks.delete();
            while (pushed < nums || d > 1) begin
                if (pushed < nums && (d < 2 || $urandom_range(0, 1) == 1)) begin
                    v = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
                    toks.push_back('{1'b1, 1'b0, v});
                    pushed++;
                    d++;
                end else begin
                    toks.push_back('{1'b0, 1'b0, opc[$urandom_range(0, 3)]});
                    d--;
                end
                if ($urandom_range(0, 15) == 0) toks.push_back('{1'b0, 1'b0, 8'h3F});
            end
            toks.push_back('{1'b0, 1'b1, 8'h00});
            m = model(toks);
            run_expr($sformatf("rnd%0d", it), m.res, m.err);
        end
        ack_delay = 0;

        check("bus_both_strobes", 32'(bad_both), 32'd0);
        check("bus_pop_empty", 32'(bad_pop), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/postfix_eval.md
Name: postfix_eval

Overview:
- Evaluates the postfix token stream produced by the infix-to-postfix converter: numbers and operator signs in, one integer result out.
- Acts as sole master and sequencer of a `stack` instance. Numbers are pushed. Each operator pops two operands, runs them through a combinational ALU, and pushes the result. The end-of-expression marker pops the final value.
- Sits directly downstream of the converter outputs.

Parameters:
- DW, 16, arithmetic and result width; two's complement.
- DEPTH, 16, stack capacity in entries; drives overflow detection.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- IN_NUMBER  in  8  unsigned operand token
- IN_NUMBER_STB  in  1  number token valid
- IN_SIGN  in  8  ASCII operator token ('+' '-' '*' '/')
- IN_SIGN_STB  in  1  sign token valid; asserted together with IN_NUMBER_STB it is the end-of-expression marker
- BUSY  out  1  high: token not accepted this cycle
- PUSH_STB  out  1  stack push request
- PUSH_DAT  out  32  push data
- PUSH_ACK  in  1  push complete, 1-cycle pulse
- POP_STB  out  1  stack pop request
- POP_DAT  in  32  pop data, valid while POP_ACK is high
- POP_ACK  in  1  pop complete, 1-cycle pulse
- RESULT  out  DW  final value
- RESULT_STB  out  1  1-cycle pulse, RESULT valid
- ERROR  out  1  sticky error flag
- ERR_CODE  out  2  0 none, 1 malformed, 2 overflow, 3 divide-by-zero

Behaviour:
- Reset (asynchronous, immediate): BUSY=0, PUSH_STB=0, POP_STB=0, PUSH_DAT=0, RESULT=0, RESULT_STB=0, ERROR=0, ERR_CODE=0, depth=0, state=IDLE. Any in-flight stack transaction is abandoned; the stack shares RST.
- Token acceptance: a token is accepted only in IDLE, on a cycle where a strobe is high and BUSY=0. BUSY is high in every state except IDLE.
- Handshake: PUSH_STB/POP_STB rise the cycle after state entry and are held until the matching ACK. They drop on the cycle after the ACK. The two strobes are never high together.
- Internal counter depth (0..DEPTH) mirrors stack occupancy: +1 per PUSH_ACK, -1 per POP_ACK.
- States:
  - IDLE: on a number -> PUSH_NUM, or ERR(2) if depth==DEPTH. On a recognised sign with depth>=2 -> POP_B; with depth<2 -> ERR(1). On an unrecognised sign character, the token is discarded and state stays IDLE. On end marker with depth==1 -> POP_FINAL; any other depth -> ERR(1).
  - PUSH_NUM: PUSH_DAT = zero-extended number; on PUSH_ACK -> IDLE. Latency from acceptance to IDLE is 3 cycles when ACK arrives the cycle after the strobe.
  - POP_B: latch POP_DAT[DW-1:0] as operand B (right operand); on POP_ACK -> POP_A.
  - POP_A: latch operand A; on POP_ACK -> CALC.
  - CALC: one cycle; register the ALU output. For '/' with B==0 -> ERR(3); otherwise -> PUSH_RES.
  - PUSH_RES: PUSH_DAT = result zero-extended to 32 bits; on PUSH_ACK -> IDLE. No overflow check is needed because depth<=DEPTH-1 here.
  - POP_FINAL: on POP_ACK, RESULT <= POP_DAT[DW-1:0] and RESULT_STB pulses the same cycle as the transition -> IDLE with depth=0.
  - ERR: ERROR=1 and ERR_CODE holds the code; BUSY=1; no stack activity. Exits only via RST.
- Arithmetic:
  - '+', '-', '*': A op B, wrapping modulo 2^DW.
  - '/': signed, truncating toward zero.
  - Operands are taken as signed DW values from the stack's low bits. RESULT is the signed DW value.
- Simultaneous events: the end marker takes priority over a single number or sign strobe. Strobes arriving while BUSY=1 are ignored; the upstream block must hold them.

Decomposition:
- Package postfix_pkg:
  - state enum (IDLE, PUSH_NUM, POP_B, POP_A, CALC, PUSH_RES, POP_FINAL, ERR)
  - op enum (ADD, SUB, MUL, DIV)
  - ERR_* code constants
  - ASCII sign constants
  - sign-to-op decode function
- One sub-module, postfix_alu: combinational; inputs A, B, op; outputs DW-bit result and div_zero.

Test Plan:
- Tokens 3, 4, '+', end (ACK one cycle after each strobe) -> RESULT_STB pulse with RESULT=7; depth=0; ERROR=0.
- Tokens 2, 3, 4, '*', '+', end -> RESULT=14. Then 9, 2, '-', end -> RESULT=7, confirming the operand order is A-B.
- Tokens 0, 7, '-', 2, '/', end -> RESULT=-3 (0xFFFD), confirming truncation toward zero.
- Tokens 7, 0, '/' -> ERROR=1, ERR_CODE=3, BUSY stuck high. After RST, 1, end -> RESULT=1.
- '+' on an empty stack -> ERR_CODE=1. Separately, 17 numbers with DEPTH=16 -> ERR_CODE=2 on the 17th, with no PUSH_STB issued for it.
- Assert RST while PUSH_STB is high, ACK withheld -> PUSH_STB and BUSY low immediately. Then 5, end -> RESULT=5.
